// File: rtl/path_count_node_mt.sv
// path_count_node_mt: per-node engine of the mesh DAG path counter.
// Holds NV = 2**NUM_TAGS saturating path counts. Entry i counts paths that
// have visited tag set i. The node collects SUM vectors from its children and
// folds in its own tag mask. It then forwards the result to each parent over
// a valid/ready link.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_valid/in_ready/in_ctrl       input packet handshake and type
//                                   (0 CONFIG, 1 PARENTS, 2 SUM, 3 RESTART)
//   in_num_children, in_tag_mask,
//   in_is_source                    CONFIG payload
//   in_num_edges, in_edges          PARENTS payload
//   in_sums                         SUM payload (entry i at i*COUNT_W)
//   out_valid/out_ready             outgoing SUM handshake
//   out_dest, out_sums              parent id and final tagged vector
//   done, overflow, err             status (overflow/err sticky)
module path_count_node_mt #(
  parameter int NODE_ID_W      = 10,
  parameter int MAX_PARENTS    = 32,
  parameter int EDGES_PER_LOAD = 4,
  parameter int NUM_TAGS       = 2,
  parameter int COUNT_W        = 48,
  parameter int CHILD_W        = 6,
  localparam int NV   = 2**NUM_TAGS,
  localparam int NE_W = $clog2(EDGES_PER_LOAD+1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1:0]                    in_ctrl,
  input  logic [CHILD_W-1:0]            in_num_children,
  input  logic [NUM_TAGS-1:0]           in_tag_mask,
  input  logic                          in_is_source,
  input  logic [NE_W-1:0]               in_num_edges,
  input  logic [EDGES_PER_LOAD*NODE_ID_W-1:0] in_edges,
  input  logic [NV*COUNT_W-1:0]         in_sums,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NODE_ID_W-1:0]          out_dest,
  output logic [NV*COUNT_W-1:0]         out_sums,
  output logic                          done,
  output logic                          overflow,
  output logic                          err
);
  localparam int PI_W = $clog2(MAX_PARENTS+1);
  localparam int PA_W = (MAX_PARENTS > 1) ? $clog2(MAX_PARENTS) : 1;
  localparam logic [1:0] C_CONFIG = 2'd0, C_PARENTS = 2'd1, C_SUM = 2'd2, C_RESTART = 2'd3;

  typedef enum logic [2:0] {IDLE, COLLECT, APPLY, SEND, DONE} state_e;
  typedef logic [NV-1:0][COUNT_W-1:0] vec_t;

  state_e                               state_q, state_d;
  vec_t                                 acc_q, acc_d;
  logic [CHILD_W-1:0]                   rcv_q, rcv_d, nch_q, nch_d;
  logic [NUM_TAGS-1:0]                  mask_q, mask_d;
  logic                                 cfg_q, cfg_d, ovf_q, ovf_d, err_q, err_d;
  logic [PI_W-1:0]                      npar_q, npar_d;
  logic [PA_W-1:0]                      sidx_q, sidx_d;
  logic [MAX_PARENTS-1:0][NODE_ID_W-1:0] par_q, par_d;

  // {carry, sum}: carry flags saturation, sum clamps to all-ones.
  function automatic logic [COUNT_W:0] sat_add(input logic [COUNT_W-1:0] a,
                                               input logic [COUNT_W-1:0] b);
    logic [COUNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[COUNT_W]) s = {1'b1, {COUNT_W{1'b1}}};
    return s;
  endfunction

  assign in_ready  = (state_q == IDLE) || (state_q == COLLECT) || (state_q == DONE);
  assign out_valid = (state_q == SEND);
  assign out_dest  = out_valid ? par_q[sidx_q] : '0;
  assign out_sums  = out_valid ? acc_q : '0;
  assign done      = (state_q == DONE);
  assign overflow  = ovf_q;
  assign err       = err_q;

  always_comb begin
    logic             accept, restart;
    logic [COUNT_W:0] t;
    vec_t             nv;
    int               ne, np;
    state_d = state_q; acc_d = acc_q; rcv_d = rcv_q; nch_d = nch_q;
    mask_d = mask_q; cfg_d = cfg_q; ovf_d = ovf_q; err_d = err_q;
    npar_d = npar_q; sidx_d = sidx_q; par_d = par_q;
    accept = in_valid && in_ready;
    restart = 1'b0;
    t = '0; nv = '0; ne = 0; np = 0;
    case (state_q)
      IDLE, COLLECT: begin
        if (accept) begin
          case (in_ctrl)
            C_CONFIG: begin
              if (cfg_q) err_d = 1'b1;
              else begin
                cfg_d = 1'b1; nch_d = in_num_children; mask_d = in_tag_mask;
                state_d = COLLECT;
                if (in_is_source) begin
                  t = sat_add(acc_q[0], COUNT_W'(1));
                  acc_d[0] = t[COUNT_W-1:0];
                  if (t[COUNT_W]) ovf_d = 1'b1;
                end
              end
            end
            C_PARENTS: begin
              ne = int'(in_num_edges);
              if (ne > EDGES_PER_LOAD) begin
                ne = EDGES_PER_LOAD; err_d = 1'b1;
              end
              for (int k = 0; k < EDGES_PER_LOAD; k++) begin
                if (k < ne) begin
                  if (int'(npar_q) + k < MAX_PARENTS)
                    par_d[PA_W'(int'(npar_q) + k)] = in_edges[k*NODE_ID_W +: NODE_ID_W];
                  else err_d = 1'b1;
                end
              end
              np = int'(npar_q) + ne;
              if (np > MAX_PARENTS) np = MAX_PARENTS;
              npar_d = PI_W'(np);
            end
            C_SUM: begin
              for (int i = 0; i < NV; i++) begin
                t = sat_add(acc_q[i], in_sums[i*COUNT_W +: COUNT_W]);
                acc_d[i] = t[COUNT_W-1:0];
                if (t[COUNT_W]) ovf_d = 1'b1;
              end
              rcv_d = rcv_q + 1'b1;
            end
            default: restart = 1'b1;
          endcase
          // Judged on post-update values so the last accept moves straight on.
          if (!restart && cfg_d) begin
            if (rcv_d == nch_d) state_d = APPLY;
            else if (rcv_d > nch_d) err_d = 1'b1;
          end
        end
      end
      APPLY: begin
        // Passing this node ORs its mask into every tag set; targets lacking
        // a mask bit are unreachable and stay zero.
        for (int j = 0; j < NV; j++) begin
          for (int i = 0; i < NV; i++) begin
            if ((i | int'(mask_q)) == j) begin
              t = sat_add(nv[j], acc_q[i]);
              nv[j] = t[COUNT_W-1:0];
              if (t[COUNT_W]) ovf_d = 1'b1;
            end
          end
        end
        acc_d  = nv;
        sidx_d = '0;
        state_d = (npar_q == '0) ? DONE : SEND;
      end
      SEND: begin
        if (out_ready) begin
          if (int'(sidx_q) == int'(npar_q) - 1) state_d = DONE;
          else sidx_d = sidx_q + 1'b1;
        end
      end
      DONE: begin
        if (accept) begin
          if (in_ctrl == C_RESTART) restart = 1'b1;
          else err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (restart) begin
      state_d = IDLE; acc_d = '0; rcv_d = '0; nch_d = '0; mask_d = '0;
      cfg_d = 1'b0; ovf_d = 1'b0; err_d = 1'b0; npar_d = '0; sidx_d = '0;
      par_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE; acc_q <= '0; rcv_q <= '0; nch_q <= '0; mask_q <= '0;
      cfg_q <= 1'b0; ovf_q <= 1'b0; err_q <= 1'b0; npar_q <= '0; sidx_q <= '0;
      par_q <= '0;
    end else begin
      state_q <= state_d; acc_q <= acc_d; rcv_q <= rcv_d; nch_q <= nch_d;
      mask_q <= mask_d; cfg_q <= cfg_d; ovf_q <= ovf_d; err_q <= err_d;
      npar_q <= npar_d; sidx_q <= sidx_d; par_q <= par_d;
    end
  end
endmodule
